// File: rtl/demux3_pkg.sv
// Shared encodings for the 1-to-3 registered demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux3_pkg;

    // Destination select carried with every input word.
    typedef enum logic [1:0] {
        SEL_DROP = 2'd0,
        SEL_CH1  = 2'd1,
        SEL_CH2  = 2'd2,
        SEL_CH3  = 2'd3
    } sel_e;

    // One-entry output slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux3_if.sv
// Bundle of the input stream, the three output channels and the drop counter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the input and on each output channel.
interface demux3_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out3_valid;
    logic             out3_ready;
    logic [WIDTH-1:0] out3_data;

    logic [CNT_W-1:0] drop_cnt;

    // Upstream producer plus the three downstream consumers.
    modport master (
        output in_valid, in_sel, in_data,
        output out1_ready, out2_ready, out3_ready,
        input  in_ready,
        input  out1_valid, out1_data,
        input  out2_valid, out2_data,
        input  out3_valid, out3_data,
        input  drop_cnt
    );

    // The router itself.
    modport slave (
        input  in_valid, in_sel, in_data,
        input  out1_ready, out2_ready, out3_ready,
        output in_ready,
        output out1_valid, out1_data,
        output out2_valid, out2_data,
        output out3_valid, out3_data,
        output drop_cnt
    );
endinterface

// File: rtl/demux3_slot.sv
// One-entry registered output slot with valid/ready drain.
// Latency: load at edge N is visible as valid/data from edge N.
// Backpressure: can_load is high when empty or draining this cycle, so a full slot refills without a bubble.
module demux3_slot
    import demux3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             can_load
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // State and payload registers; reset empties the slot and zeroes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: a load always wins over a same-cycle drain so valid never drops.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            data_d = load_data;
        end
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (ready && !load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Outputs: data is held after a drain, consumers qualify it with valid.
    always_comb begin
        valid    = (state_q == SLOT_FULL);
        can_load = (state_q == SLOT_EMPTY) || ready;
        data     = data_q;
    end

endmodule

// File: rtl/demux3_router.sv
// Steers each input word to channel 1/2/3 by its select, or drops and counts it on select 0.
// Latency: one edge from accept to outK_valid; drops counted at the accepting edge.
// Backpressure: in_ready follows only the addressed slot, so one stalled channel never blocks the others.
module demux3_router
    import demux3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    demux3_if.slave  bus
);

    logic [3:1]       can_load;
    logic [3:1]       load;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Select decode: ready mux, per-channel load strobes, saturating drop count.
    always_comb begin
        load       = '0;
        drop_cnt_d = drop_cnt_q;
        case (bus.in_sel)
            SEL_CH1: bus.in_ready = can_load[1];
            SEL_CH2: bus.in_ready = can_load[2];
            SEL_CH3: bus.in_ready = can_load[3];
            default: bus.in_ready = 1'b1;
        endcase
        if (bus.in_valid && bus.in_ready) begin
            case (bus.in_sel)
                SEL_CH1: load[1] = 1'b1;
                SEL_CH2: load[2] = 1'b1;
                SEL_CH3: load[3] = 1'b1;
                default: begin
                    if (drop_cnt_q != {CNT_W{1'b1}}) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
        bus.drop_cnt = drop_cnt_q;
    end

    // Drop counter register; clears only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    demux3_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[1]),
        .load_data (bus.in_data),
        .valid     (bus.out1_valid),
        .ready     (bus.out1_ready),
        .data      (bus.out1_data),
        .can_load  (can_load[1])
    );

    demux3_slot #(.WIDTH(WIDTH)) u_slot2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[2]),
        .load_data (bus.in_data),
        .valid     (bus.out2_valid),
        .ready     (bus.out2_ready),
        .data      (bus.out2_data),
        .can_load  (can_load[2])
    );

    demux3_slot #(.WIDTH(WIDTH)) u_slot3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[3]),
        .load_data (bus.in_data),
        .valid     (bus.out3_valid),
        .ready     (bus.out3_ready),
        .data      (bus.out3_data),
        .can_load  (can_load[3])
    );

endmodule

// File: tb/tb_demux3_router.sv
// Directed bench for demux3_router with a per-cycle reference model.
// Latency: n/a.
// Backpressure: consumer readies driven directly by the stimulus.
module tb_demux3_router;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux3_if #(.WIDTH(8), .CNT_W(8)) bus ();

    demux3_router #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a queue of capacity one, plus a saturating drop tally.
    bit         m_occ [1:3];
    logic [7:0] m_dat [1:3];
    int         m_cnt;

    function automatic logic cons_rdy(input int k);
        case (k)
            1:       return bus.out1_ready;
            2:       return bus.out2_ready;
            default: return bus.out3_ready;
        endcase
    endfunction

    function automatic logic exp_in_ready();
        int k;
        k = int'(bus.in_sel);
        if (k == 0) return 1'b1;
        return !m_occ[k] || cons_rdy(k);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= 3; k++) begin
                m_occ[k] = 1'b0;
                m_dat[k] = 8'h00;
            end
            m_cnt = 0;
        end else begin
            logic acc;
            int   s;
            acc = bus.in_valid && exp_in_ready();
            s   = int'(bus.in_sel);
            for (int k = 1; k <= 3; k++) begin
                if (m_occ[k] && cons_rdy(k)) m_occ[k] = 1'b0;
                if (acc && s == k) begin
                    m_occ[k] = 1'b1;
                    m_dat[k] = bus.in_data;
                end
            end
            if (acc && s == 0 && m_cnt < 255) m_cnt++;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("in_ready",   32'(bus.in_ready),   32'(exp_in_ready()));
            check("out1_valid", 32'(bus.out1_valid), 32'(m_occ[1]));
            check("out1_data",  32'(bus.out1_data),  32'(m_dat[1]));
            check("out2_valid", 32'(bus.out2_valid), 32'(m_occ[2]));
            check("out2_data",  32'(bus.out2_data),  32'(m_dat[2]));
            check("out3_valid", 32'(bus.out3_valid), 32'(m_occ[3]));
            check("out3_data",  32'(bus.out3_data),  32'(m_dat[3]));
            check("drop_cnt",   32'(bus.drop_cnt),   32'(m_cnt));
        end
    end

    task automatic set_rdy(input logic r1, input logic r2, input logic r3);
        bus.out1_ready = r1;
        bus.out2_ready = r2;
        bus.out3_ready = r3;
    endtask

    // Present one word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [1:0] s, input logic [7:0] d);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: word %0h sel %0d not accepted within 50 cycles", d, s);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd0;
        bus.in_data  = 8'h00;
        set_rdy(1'b1, 1'b1, 1'b1);

        // Reset state.
        #12;
        check("rst_out1_valid", 32'(bus.out1_valid), 32'h0);
        check("rst_out2_data",  32'(bus.out2_data),  32'h0);
        check("rst_drop_cnt",   32'(bus.drop_cnt),   32'h0);
        check("rst_in_ready",   32'(bus.in_ready),   32'h1);
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
        step();

        // One word per channel, readies high.
        send(2'd1, 8'hA5);
        check("ch1_valid", 32'(bus.out1_valid), 32'h1);
        check("ch1_data",  32'(bus.out1_data),  32'hA5);
        send(2'd2, 8'h3C);
        check("ch1_drained", 32'(bus.out1_valid), 32'h0);
        check("ch1_hold",    32'(bus.out1_data),  32'hA5);
        check("ch2_data",    32'(bus.out2_data),  32'h3C);
        send(2'd3, 8'h0F);
        check("ch3_valid", 32'(bus.out3_valid), 32'h1);
        check("ch3_data",  32'(bus.out3_data),  32'h0F);
        check("no_drops",  32'(bus.drop_cnt),   32'h0);
        step();

        // Channel 2 stalled: second word waits, then drain and refill share an edge.
        set_rdy(1'b1, 1'b0, 1'b1);
        send(2'd2, 8'h11);
        check("stall_first_valid", 32'(bus.out2_valid), 32'h1);
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'h22;
        @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready),  32'h0);
        check("stall_data",     32'(bus.out2_data), 32'h11);
        step();
        bus.out2_ready = 1'b1;
        @(negedge clk);
        check("refill_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid   = 1'b0;
        bus.out2_ready = 1'b0;
        check("refill_valid", 32'(bus.out2_valid), 32'h1);
        check("refill_data",  32'(bus.out2_data),  32'h22);

        // Other channels flow past the stalled one.
        send(2'd1, 8'h77);
        check("bypass1_data", 32'(bus.out1_data), 32'h77);
        send(2'd3, 8'h88);
        check("bypass3_data", 32'(bus.out3_data),  32'h88);
        check("ch2_still",    32'(bus.out2_valid), 32'h1);
        check("ch2_still_d",  32'(bus.out2_data),  32'h22);

        // 260 drops, counter saturates.
        set_rdy(1'b1, 1'b1, 1'b1);
        step();
        step();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        for (int i = 0; i < 260; i++) begin
            bus.in_data = 8'(i);
            step();
            if (i == 2) check("drop_cnt_3", 32'(bus.drop_cnt), 32'h3);
        end
        bus.in_valid = 1'b0;
        check("drop_sat",    32'(bus.drop_cnt),   32'hFF);
        check("drop_no_out", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h0);
        step();
        step();
        check("drop_hold", 32'(bus.drop_cnt), 32'hFF);

        // Fill all slots, then a partial-cycle reset.
        set_rdy(1'b0, 1'b0, 1'b0);
        send(2'd1, 8'h01);
        send(2'd2, 8'h02);
        send(2'd3, 8'h03);
        check("filled", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valids", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h0);
        check("arst_datas",  32'({bus.out1_data, bus.out2_data, bus.out3_data}), 32'h0);
        check("arst_cnt",    32'(bus.drop_cnt), 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            check("post_arst_in_ready", 32'(bus.in_ready), 32'h1);
        end
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
